// File: rtl/conv_pkg.sv
// Shared constants and helpers for the 3x3 raster-to-window stage.
package conv_pkg;

    // Default geometry: 8-bit pixels, 28x28 frames.
    localparam int I_W_DEF   = 8;
    localparam int IMG_W_DEF = 28;
    localparam int IMG_H_DEF = 28;

    // Square kernel edge length.
    localparam int KERNEL = 3;

    // Number of fully-inside windows produced per default-sized frame.
    localparam int WIN_COUNT = (IMG_W_DEF - 2) * (IMG_H_DEF - 2);

    // Slice index of window element (row r, column c) in the packed window.
    function automatic int win_idx(input int r, input int c);
        return KERNEL * r + c;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// One image line of delay: a DEPTH-deep, I_W-wide shift line that advances
// only when enabled. The output is the pixel pushed DEPTH enables ago.
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int I_W   = I_W_DEF,
    parameter int DEPTH = IMG_W_DEF
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_en,
    input  logic [I_W-1:0] i_din,
    output logic [I_W-1:0] o_dout
);

    logic [I_W-1:0] tap_reg [DEPTH];

    // Shift the whole line by one pixel per enabled beat; clear on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tap_reg[i] <= '0;
            end
        end else if (i_en) begin
            tap_reg[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                tap_reg[i] <= tap_reg[i-1];
            end
        end
    end

    assign o_dout = tap_reg[DEPTH-1];

endmodule

// File: rtl/conv_window_gen.sv
// Raster-to-window stage: turns a row-major pixel stream into 3x3 windows
// for the convolution MAC, emitting only windows fully inside the image,
// plus a one-cycle end-of-frame pulse.
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int I_W   = I_W_DEF,
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_valid,
    input  logic [I_W-1:0]                i_pixel,
    output logic                          o_valid,
    output logic [KERNEL*KERNEL*I_W-1:0]  o_window,
    output logic                          o_frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    // First column/row at which a full window is available.
    localparam logic [CW-1:0] COL_WIN  = CW'(KERNEL - 1);
    localparam logic [RW-1:0] ROW_WIN  = RW'(KERNEL - 1);

    // Position of the pixel that will be accepted next.
    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;

    logic col_last;
    logic row_last;
    logic window_ok;
    logic frame_end;

    logic [I_W-1:0] line1_out;
    logic [I_W-1:0] line2_out;

    // Per-row input into the right-hand column of the window: top row from
    // two lines back, middle row from one line back, bottom row live.
    logic [I_W-1:0] feed [KERNEL];

    logic [I_W-1:0] win_reg  [KERNEL][KERNEL];
    logic [I_W-1:0] win_next [KERNEL][KERNEL];

    logic [KERNEL*KERNEL*I_W-1:0] window_flat;

    logic                         valid_reg;
    logic                         frame_done_reg;
    logic [KERNEL*KERNEL*I_W-1:0] window_reg;

    assign col_last  = (col_reg == COL_LAST);
    assign row_last  = (row_reg == ROW_LAST);
    // Gating on both column and row keeps windows from straddling a line wrap
    // or reaching back into the previous frame's stale line contents.
    assign window_ok = i_valid && (col_reg >= COL_WIN) && (row_reg >= ROW_WIN);
    assign frame_end = i_valid && col_last && row_last;

    // Raster position tracking; advances only on accepted pixels.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (i_valid) begin
            if (col_last) begin
                col_reg <= '0;
                row_reg <= row_last ? '0 : row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end
    end

    conv_line_buffer #(
        .I_W   (I_W),
        .DEPTH (IMG_W)
    ) u_line1 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_valid),
        .i_din   (i_pixel),
        .o_dout  (line1_out)
    );

    conv_line_buffer #(
        .I_W   (I_W),
        .DEPTH (IMG_W)
    ) u_line2 (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_en    (i_valid),
        .i_din   (line1_out),
        .o_dout  (line2_out)
    );

    // Route the three vertical taps to their window rows.
    always_comb begin
        feed[0] = line2_out;
        feed[1] = line1_out;
        feed[2] = i_pixel;
    end

    // Window contents after this beat's shift: every row moves left by one
    // and takes its new right-hand pixel from its feed.
    always_comb begin
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                win_next[r][c] = win_reg[r][c+1];
            end
            win_next[r][KERNEL-1] = feed[r];
        end
    end

    // Window shift register, held during input gaps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    win_reg[r][c] <= '0;
                end
            end
        end else if (i_valid) begin
            win_reg <= win_next;
        end
    end

    // Pack the post-shift window, top-left element in the lowest slice.
    generate
        for (genvar gi = 0; gi < KERNEL; gi++) begin : g_row
            for (genvar gj = 0; gj < KERNEL; gj++) begin : g_col
                assign window_flat[I_W*win_idx(gi, gj) +: I_W] = win_next[gi][gj];
            end
        end
    endgenerate

    // Registered outputs; the window register only loads on a valid window
    // so o_window holds the last emitted window between strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_reg      <= 1'b0;
            frame_done_reg <= 1'b0;
            window_reg     <= '0;
        end else begin
            valid_reg      <= window_ok;
            frame_done_reg <= frame_end;
            if (window_ok) begin
                window_reg <= window_flat;
            end
        end
    end

    assign o_valid      = valid_reg;
    assign o_frame_done = frame_done_reg;
    assign o_window     = window_reg;

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: every driven cycle pushes the
// expected output (from a 2-D image model) and a monitor pops and compares.
module tb_conv_window_gen;

    localparam int IW   = 8;
    localparam int W    = 28;
    localparam int H    = 28;
    localparam int NWIN = (W - 2) * (H - 2);
    localparam int WB   = 9 * IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_pixel = '0;
    logic          out_valid;
    logic [WB-1:0] out_window;
    logic          out_done;

    always #5 clk = ~clk;

    conv_window_gen #(
        .I_W   (IW),
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_valid      (in_valid),
        .i_pixel      (in_pixel),
        .o_valid      (out_valid),
        .o_window     (out_window),
        .o_frame_done (out_done)
    );

    typedef struct packed {
        logic          v;
        logic          d;
        logic [WB-1:0] w;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [IW-1:0] img [H][W];
    int            m_row = 0;
    int            m_col = 0;
    bit            mon_en = 1'b0;
    logic [WB-1:0] cap_win [NWIN];
    logic [WB-1:0] ref_win [NWIN];
    int            cap_idx = 0;
    int            last_count = 0;
    int            frames_done = 0;

    function automatic logic [IW-1:0] pix(input int r, input int c, input bit aa);
        return aa ? 8'hAA : 8'((r * 28 + c) % 256);
    endfunction

    // Drive one cycle and push what the DUT must show one cycle later.
    task automatic cycle(input bit v, input logic [IW-1:0] p);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        in_pixel = v ? p : 8'($urandom_range(0, 255));
        e = '0;
        if (v) begin
            img[m_row][m_col] = p;
            if (m_row >= 2 && m_col >= 2) begin
                e.v = 1'b1;
                for (int r = 0; r < 3; r++)
                    for (int c = 0; c < 3; c++)
                        e.w[IW*(3*r+c) +: IW] = img[m_row-2+r][m_col-2+c];
            end
            e.d = (m_row == H - 1) && (m_col == W - 1);
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col = m_col + 1;
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00);
    endtask

    task automatic run_frame(input bit aa, input bit gaps);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                cycle(1'b1, pix(r, c, aa));
                if (gaps) cycle(1'b0, 8'h00);
            end
    endtask

    // Monitor: compare registered outputs 1 ns after each rising edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (mon_en) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            checks++;
            if (out_valid !== e.v) begin
                errors++;
                $display("FAIL o_valid t=%0t got %b want %b", $time, out_valid, e.v);
            end
            if (e.v) begin
                checks++;
                if (out_window !== e.w) begin
                    errors++;
                    $display("FAIL o_window t=%0t got %h want %h", $time, out_window, e.w);
                end
            end
            checks++;
            if (out_done !== e.d) begin
                errors++;
                $display("FAIL o_frame_done t=%0t got %b want %b", $time, out_done, e.d);
            end
            if (out_valid === 1'b1) begin
                if (cap_idx < NWIN) cap_win[cap_idx] = out_window;
                cap_idx++;
            end
            if (out_done === 1'b1) begin
                last_count = cap_idx;
                cap_idx = 0;
                frames_done++;
            end
        end
    end

    task automatic check_frame_count(input string name, input int f0, input int nfr);
        checks++;
        if (frames_done - f0 !== nfr || last_count !== NWIN) begin
            errors++;
            $display("FAIL %s frames got %0d want %0d, windows got %0d want %0d",
                     name, frames_done - f0, nfr, last_count, NWIN);
        end
    endtask

    task automatic compare_ref(input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < NWIN; i++) if (cap_win[i] !== ref_win[i]) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s window sequence got %0d differing want 0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_done !== 1'b0 || out_window !== '0) begin
            errors++;
            $display("FAIL reset_state got v=%b d=%b w=%h want 0 0 0", out_valid, out_done, out_window);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_continuous();
        int f0;
        f0 = frames_done;
        run_frame(1'b0, 1'b0);
        idle(3);
        check_frame_count("continuous", f0, 1);
        checks++;
        if (cap_win[0][7:0] !== 8'd0 || cap_win[0][39:32] !== 8'd29 || cap_win[0][71:64] !== 8'd58) begin
            errors++;
            $display("FAIL first_window got tl=%0d c=%0d br=%0d want 0 29 58",
                     cap_win[0][7:0], cap_win[0][39:32], cap_win[0][71:64]);
        end
        for (int i = 0; i < NWIN; i++) ref_win[i] = cap_win[i];
        $display("test_continuous done windows=%0d", last_count);
    endtask

    task automatic test_gaps();
        int f0;
        f0 = frames_done;
        run_frame(1'b0, 1'b1);
        idle(3);
        check_frame_count("gaps", f0, 1);
        compare_ref("gaps");
        $display("test_gaps done windows=%0d", last_count);
    endtask

    task automatic test_col_edge();
        // Window index of (5,27): three full window rows of 26, plus 25.
        checks++;
        if (cap_win[103][71:64] !== 8'd167) begin
            errors++;
            $display("FAIL col_edge br got %0d want 167", cap_win[103][71:64]);
        end
        // Next window after the wrap is (6,2); (6,0),(6,1) must not emit.
        checks++;
        if (cap_win[104][71:64] !== 8'd170) begin
            errors++;
            $display("FAIL col_wrap next br got %0d want 170", cap_win[104][71:64]);
        end
        $display("test_col_edge done");
    endtask

    task automatic test_last_pixel();
        checks++;
        if (cap_win[NWIN-1][71:64] !== 8'd15) begin
            errors++;
            $display("FAIL last_window br got %0d want 15", cap_win[NWIN-1][71:64]);
        end
        $display("test_last_pixel done");
    endtask

    task automatic test_back_to_back();
        int f0;
        logic [WB-1:0] aa;
        aa = {9{8'hAA}};
        f0 = frames_done;
        run_frame(1'b0, 1'b0);
        run_frame(1'b1, 1'b0);
        idle(3);
        check_frame_count("back_to_back", f0, 2);
        checks++;
        if (cap_win[0] !== aa) begin
            errors++;
            $display("FAIL b2b_first_window got %h want %h", cap_win[0], aa);
        end
        $display("test_back_to_back done windows=%0d", last_count);
    endtask

    task automatic test_reset_mid();
        int f0;
        for (int r = 0; r < 10; r++)
            for (int c = 0; c < W; c++) cycle(1'b1, pix(r, c, 1'b0));
        for (int c = 0; c < 15; c++) cycle(1'b1, pix(10, c, 1'b0));
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset o_valid got %b want 1", out_valid);
        end
        mon_en = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_done !== 1'b0 || out_window !== '0) begin
            errors++;
            $display("FAIL async_reset got v=%b d=%b w=%h want 0 0 0", out_valid, out_done, out_window);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        m_row = 0;
        m_col = 0;
        cap_idx = 0;
        mon_en = 1'b1;
        f0 = frames_done;
        run_frame(1'b0, 1'b0);
        idle(3);
        check_frame_count("after_reset", f0, 1);
        compare_ref("after_reset");
        $display("test_reset_mid done windows=%0d", last_count);
    endtask

    initial begin
        test_reset();
        test_continuous();
        test_gaps();
        test_col_edge();
        test_last_pixel();
        test_back_to_back();
        test_reset_mid();
        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
